// File: rtl/music_pkg.sv
// Shared types and constants for the song sequencer: FSM states, reserved
// note codes and the layout of a note ROM word.
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [7:0] END_CODE  = 8'd99;

    localparam int BEATS_MSB = 11;
    localparam int BEATS_LSB = 8;
    localparam int NOTE_MSB  = 7;
    localparam int NOTE_LSB  = 0;

    function automatic logic [3:0] rom_beats(input logic [11:0] word);
        return word[BEATS_MSB:BEATS_LSB];
    endfunction

    function automatic logic [7:0] rom_note(input logic [11:0] word);
        return word[NOTE_MSB:NOTE_LSB];
    endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Control and note-ROM bus of the song sequencer. The master side is the
// sequencer itself; the slave side is the ROM plus whoever starts/stops it.
interface music_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [11:0]       rom_q;
    logic [7:0]        note_code;
    logic              busy;
    logic              done;

    modport master (
        input  start, stop, pause, loop_en, rom_q,
        output rom_addr, rom_rd, note_code, busy, done
    );

    modport slave (
        output start, stop, pause, loop_en, rom_q,
        input  rom_addr, rom_rd, note_code, busy, done
    );
endinterface

// File: rtl/music_sequencer_beat_timer.sv
// Note duration timer: counts tick_max+1 cycles per beat for a loaded number of
// beats, freezing while en_i is low. expire_o flags the final counted cycle.
module beat_timer #(
    parameter int TICK_W = 18
) (
    input  logic              clk_1M,
    input  logic              rst,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [3:0]        beats_i,
    input  logic [TICK_W-1:0] tick_max_i,
    output logic              expire_o
);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TICK_W-1:0] tick_max_q, tick_max_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              last_tick;

    assign last_tick = (tick_cnt_q == tick_max_q);
    assign expire_o  = en_i && last_tick && (beat_cnt_q <= 4'd1);

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        beat_cnt_d = beat_cnt_q;
        tick_max_d = tick_max_q;
        if (load_i) begin
            tick_cnt_d = '0;
            // A zero beat count still plays one beat
            beat_cnt_d = (beats_i == 4'd0) ? 4'd1 : beats_i;
            tick_max_d = tick_max_i;
        end else if (en_i) begin
            if (last_tick) begin
                tick_cnt_d = '0;
                if (beat_cnt_q != 4'd0) begin
                    beat_cnt_d = beat_cnt_q - 4'd1;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk_1M) begin
        if (rst) begin
            tick_cnt_q <= '0;
            beat_cnt_q <= '0;
            tick_max_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            tick_max_q <= tick_max_d;
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Song sequencer: walks the note ROM, holds each note for its beat count,
// inserts an articulation gap, and handles pause, stop and looping.
//   state | meaning
//   IDLE  | not playing, outputs silent
//   FETCH | rom_rd strobe at rom_addr
//   LATCH | ROM word valid; end marker or load note and timer
//   PLAY  | note audible, beat timer running (frozen by pause)
//   GAP   | silent articulation gap between notes
module music_sequencer
    import music_pkg::*;
#(
    parameter int         ADDR_W     = 8,
    parameter int         BEAT_TICKS = 250000,
    parameter int         GAP_TICKS  = 20000,
    parameter int         TICK_W     = 18,
    parameter logic [7:0] END_CODE   = music_pkg::END_CODE
) (
    input  logic                clk_1M,
    input  logic                rst,
    music_sequencer_if.master   bus
);

    localparam logic [TICK_W-1:0] BEAT_MAX  = TICK_W'(BEAT_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_MAX   = TICK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_rd_q, rom_rd_d;
    logic [7:0]        note_code_q, note_code_d;
    logic [7:0]        note_hold_q, note_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tmr_load, tmr_en, tmr_expire, advance;
    logic [3:0]        tmr_beats;
    logic [TICK_W-1:0] tmr_max;

    beat_timer #(.TICK_W(TICK_W)) u_beat_timer (
        .clk_1M     (clk_1M),
        .rst        (rst),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .beats_i    (tmr_beats),
        .tick_max_i (tmr_max),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        rom_rd_d    = 1'b0;
        note_code_d = NOTE_REST;
        note_hold_d = note_hold_q;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        tmr_beats   = 4'd1;
        tmr_max     = BEAT_MAX;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d    = ST_FETCH;
                    rom_addr_d = '0;
                    rom_rd_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (rom_note(bus.rom_q) == END_CODE) begin
                    rom_addr_d = '0;
                    if (bus.loop_en) begin
                        state_d  = ST_FETCH;
                        rom_rd_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d     = ST_PLAY;
                    note_hold_d = rom_note(bus.rom_q);
                    note_code_d = bus.pause ? NOTE_REST : rom_note(bus.rom_q);
                    tmr_load    = 1'b1;
                    tmr_beats   = rom_beats(bus.rom_q);
                end
            end
            ST_PLAY: begin
                tmr_en      = !bus.pause;
                note_code_d = bus.pause ? NOTE_REST : note_hold_q;
                if (tmr_expire) begin
                    if (GAP_TICKS > 0) begin
                        state_d     = ST_GAP;
                        note_code_d = NOTE_REST;
                        tmr_load    = 1'b1;
                        tmr_max     = GAP_MAX;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                tmr_en = !bus.pause;
                if (tmr_expire) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            note_code_d = NOTE_REST;
            if (rom_addr_q != ADDR_LAST) begin
                state_d    = ST_FETCH;
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                rom_rd_d   = 1'b1;
            end else if (bus.loop_en) begin
                state_d    = ST_FETCH;
                rom_addr_d = '0;
                rom_rd_d   = 1'b1;
            end else begin
                state_d    = ST_IDLE;
                rom_addr_d = '0;
                done_d     = 1'b1;
            end
        end

        // Stop wins over everything except reset and never reports completion
        if (bus.stop) begin
            state_d     = ST_IDLE;
            rom_addr_d  = '0;
            rom_rd_d    = 1'b0;
            note_code_d = NOTE_REST;
            done_d      = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_1M) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            rom_rd_q    <= 1'b0;
            note_code_q <= NOTE_REST;
            note_hold_q <= NOTE_REST;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            rom_rd_q    <= rom_rd_d;
            note_code_q <= note_code_d;
            note_hold_q <= note_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_rd    = rom_rd_q;
    assign bus.note_code = note_code_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer with BEAT_TICKS=4, GAP_TICKS=2, ADDR_W=3:
// per-cycle expectation tables plus hand-written loop/wrap sequences.
module tb_music_sequencer;

    logic clk_1M = 1'b0;
    logic rst;

    music_sequencer_if #(.ADDR_W(3)) bus ();

    music_sequencer #(
        .ADDR_W     (3),
        .BEAT_TICKS (4),
        .GAP_TICKS  (2),
        .TICK_W     (4)
    ) dut (
        .clk_1M (clk_1M),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_1M = ~clk_1M;

    logic [11:0] rom [8];

    always @(posedge clk_1M) begin
        if (bus.rom_rd) bus.rom_q <= rom[bus.rom_addr];
    end

    typedef struct {
        int         n;
        logic       rst;
        logic       start;
        logic       stop;
        logic       pause;
        logic [7:0] note;
        logic       rd;
        logic       busy;
        logic       done;
        logic [2:0] addr;
    } seg_t;

    seg_t tbl[$];
    int   n_checks;
    int   n_pass;
    int   audible;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic add(input int n, input logic r, input logic sta, input logic sto, input logic pa,
                       input logic [7:0] note, input logic rd, input logic busy, input logic done,
                       input logic [2:0] addr);
        seg_t s;
        s.n = n; s.rst = r; s.start = sta; s.stop = sto; s.pause = pa;
        s.note = note; s.rd = rd; s.busy = busy; s.done = done; s.addr = addr;
        tbl.push_back(s);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    endtask

    // Outputs packed as {note, rd, busy, done, addr}
    task automatic run_table(input string name);
        int cyc = 0;
        audible = 0;
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                @(posedge clk_1M); #1;
                rst = tbl[i].rst; bus.start = tbl[i].start;
                bus.stop = tbl[i].stop; bus.pause = tbl[i].pause;
                @(negedge clk_1M);
                if (bus.note_code == 8'd21) audible++;
                check(name, cyc,
                      {18'd0, bus.note_code, bus.rom_rd, bus.busy, bus.done, bus.rom_addr},
                      {18'd0, tbl[i].note, tbl[i].rd, tbl[i].busy, tbl[i].done, tbl[i].addr});
                cyc++;
            end
        end
        idle_inputs();
        tbl.delete();
    endtask

    task automatic do_reset();
        @(posedge clk_1M); #1;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk_1M); #1;
        @(negedge clk_1M);
        check("reset", 0, {bus.note_code, bus.rom_rd, bus.busy, bus.done, bus.rom_addr}, 32'd0);
        @(posedge clk_1M); #1;
        rst = 1'b0;
    endtask

    task automatic load_rom(input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] w2);
        for (int i = 0; i < 8; i++) rom[i] = 12'h000;
        rom[0] = w0; rom[1] = w1; rom[2] = w2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fetches, last_fetch, done_cyc;
        logic busy_at_done;
        logic [7:0] codes [8];

        n_checks = 0; n_pass = 0; audible = 0;
        idle_inputs();
        bus.loop_en = 1'b0;
        codes = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd21};

        // Single two-beat note then end marker
        load_rom({4'd2, 8'd21}, {4'd0, 8'd99}, 12'h000);
        do_reset();
        add(1, 0,1,0,0,  8'd0, 0,0,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(8, 0,0,0,0, 8'd21, 0,1,0, 3'd0);
        add(2, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 0,0,1, 3'd0);
        add(2, 0,0,0,0,  8'd0, 0,0,0, 3'd0);
        run_table("single_note");
        check("single_audible", 0, audible, 8);

        // Zero beat count plays one beat; rest note is silent but timed
        load_rom({4'd0, 8'd15}, {4'd1, 8'd0}, {4'd0, 8'd99});
        do_reset();
        add(1, 0,1,0,0,  8'd0, 0,0,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(4, 0,0,0,0, 8'd15, 0,1,0, 3'd0);
        add(2, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd1);
        add(4, 0,0,0,0,  8'd0, 0,1,0, 3'd1);
        add(2, 0,0,0,0,  8'd0, 0,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd2);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd2);
        add(1, 0,0,0,0,  8'd0, 0,0,1, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,0,0, 3'd0);
        run_table("beats0_rest");

        // Pause for 7 cycles mid-note
        load_rom({4'd2, 8'd21}, {4'd0, 8'd99}, 12'h000);
        do_reset();
        add(1, 0,1,0,0,  8'd0, 0,0,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(2, 0,0,0,0, 8'd21, 0,1,0, 3'd0);
        add(1, 0,0,0,1, 8'd21, 0,1,0, 3'd0);
        add(6, 0,0,0,1,  8'd0, 0,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(5, 0,0,0,0, 8'd21, 0,1,0, 3'd0);
        add(2, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 0,0,1, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,0,0, 3'd0);
        run_table("pause");
        check("pause_audible", 0, audible, 8);

        // Stop during the second note, then restart from address 0
        load_rom({4'd1, 8'd21}, {4'd1, 8'd22}, {4'd0, 8'd99});
        do_reset();
        add(1, 0,1,0,0,  8'd0, 0,0,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(4, 0,0,0,0, 8'd21, 0,1,0, 3'd0);
        add(2, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd1);
        add(1, 0,0,0,0, 8'd22, 0,1,0, 3'd1);
        add(1, 0,0,1,0, 8'd22, 0,1,0, 3'd1);
        add(2, 0,0,0,0,  8'd0, 0,0,0, 3'd0);
        add(1, 0,1,0,0,  8'd0, 0,0,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(2, 0,0,0,0, 8'd21, 0,1,0, 3'd0);
        add(1, 0,0,1,0, 8'd21, 0,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,0,0, 3'd0);
        run_table("stop_restart");

        // Start while busy ignored; reset in PLAY; start+stop in IDLE
        load_rom({4'd2, 8'd21}, {4'd0, 8'd99}, 12'h000);
        do_reset();
        add(1, 0,1,0,0,  8'd0, 0,0,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(1, 0,0,0,0, 8'd21, 0,1,0, 3'd0);
        add(1, 0,1,0,0, 8'd21, 0,1,0, 3'd0);
        add(1, 1,0,0,0, 8'd21, 0,1,0, 3'd0);
        add(1, 0,1,1,0,  8'd0, 0,0,0, 3'd0);
        add(2, 0,0,0,0,  8'd0, 0,0,0, 3'd0);
        run_table("collisions");

        // End marker with loop_en restarts at address 0
        do_reset();
        bus.loop_en = 1'b1;
        add(1, 0,1,0,0,  8'd0, 0,0,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(8, 0,0,0,0, 8'd21, 0,1,0, 3'd0);
        add(2, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd1);
        add(1, 0,0,0,0,  8'd0, 1,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,1,0, 3'd0);
        add(1, 0,0,1,0, 8'd21, 0,1,0, 3'd0);
        add(1, 0,0,0,0,  8'd0, 0,0,0, 3'd0);
        run_table("end_loop");

        // Full ROM without end marker: address wraps 7 -> 0 when looping
        for (int i = 0; i < 8; i++) rom[i] = {4'd1, codes[i]};
        do_reset();
        bus.loop_en = 1'b1;
        @(posedge clk_1M); #1; bus.start = 1'b1;
        @(posedge clk_1M); #1; bus.start = 1'b0;
        fetches = 0; last_fetch = 0;
        for (int c = 1; c < 200 && fetches < 10; c++) begin
            @(negedge clk_1M);
            if (bus.rom_rd) begin
                check("wrap_addr", c, bus.rom_addr, fetches % 8);
                check("wrap_spacing", c, c - last_fetch, (fetches == 0) ? 1 : 8);
                last_fetch = c;
                fetches++;
            end
        end
        check("wrap_fetch_count", 0, fetches, 10);
        @(posedge clk_1M); #1; bus.stop = 1'b1;
        @(posedge clk_1M); #1; bus.stop = 1'b0;
        @(negedge clk_1M);
        check("wrap_stop_busy", 0, bus.busy, 0);

        // Same ROM without looping: done after the note at address 7
        do_reset();
        bus.loop_en = 1'b0;
        @(posedge clk_1M); #1; bus.start = 1'b1;
        @(posedge clk_1M); #1; bus.start = 1'b0;
        fetches = 0; done_cyc = -1; busy_at_done = 1'b1;
        for (int c = 1; c < 200 && done_cyc < 0; c++) begin
            @(negedge clk_1M);
            if (bus.rom_rd) fetches++;
            if (bus.done) begin
                done_cyc = c;
                busy_at_done = bus.busy;
            end
        end
        check("nowrap_done_cycle", 0, done_cyc, 65);
        check("nowrap_fetches", 0, fetches, 8);
        check("nowrap_busy_at_done", 0, busy_at_done, 0);
        @(negedge clk_1M);
        check("nowrap_done_pulse", 0, bus.done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
